// File: rtl/pipeline_control_if.sv
// Handshake/control bundle between the fetch/decode datapath and the
// pipeline sequencing/hazard controller.
//   master : datapath side; drives the fetch/decode status and consumes
//            the controls.
//   slave  : controller side; consumes the status and drives the controls.
// Status : endProgram, branchTaken, jump, idExMemRead, idExRd, ifIdRs1,
//          ifIdRs2, ifIdUsesRs2
// Control: pcSelect, stall, ifIdFlush, idExBubble, halted, state, stallCount
interface pipeline_control_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   endProgram;
  logic                   branchTaken;
  logic                   jump;
  logic                   idExMemRead;
  logic [4:0]             idExRd;
  logic [4:0]             ifIdRs1;
  logic [4:0]             ifIdRs2;
  logic                   ifIdUsesRs2;
  logic                   pcSelect;
  logic                   stall;
  logic                   ifIdFlush;
  logic                   idExBubble;
  logic                   halted;
  logic [1:0]             state;
  logic [STALL_CNT_W-1:0] stallCount;

  modport master (
    output endProgram, branchTaken, jump, idExMemRead, idExRd,
           ifIdRs1, ifIdRs2, ifIdUsesRs2,
    input  pcSelect, stall, ifIdFlush, idExBubble, halted, state, stallCount
  );

  modport slave (
    input  endProgram, branchTaken, jump, idExMemRead, idExRd,
           ifIdRs1, ifIdRs2, ifIdUsesRs2,
    output pcSelect, stall, ifIdFlush, idExBubble, halted, state, stallCount
  );
endinterface

// File: rtl/pipeline_control.sv
// Sequencing and hazard controller for the pipelined fetch unit.
// - Selects the start address for the first fetch after reset.
// - Stalls PC/IF-ID and bubbles ID/EX on load-use hazards.
// - Flushes IF/ID on taken branches and jumps.
// - On end of program, drains for DRAIN_CYCLES cycles, then halts.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : pipeline_control_if.slave (status in, controls out)
module pipeline_control #(
  parameter int DRAIN_CYCLES = 4,   // 1..15
  parameter int STALL_CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  pipeline_control_if.slave bus
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t                 state_q;
  logic [3:0]             drain_q;
  logic [STALL_CNT_W-1:0] cnt_q;

  logic hz;
  logic redirect;
  logic enter_drain;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // x0 never carries a dependency.
  always_comb begin
    hz = bus.idExMemRead && (bus.idExRd != 5'd0) &&
         ((bus.idExRd == bus.ifIdRs1) ||
          (bus.ifIdUsesRs2 && (bus.idExRd == bus.ifIdRs2)));
  end

  // A stall wins over a redirect; the redirect re-presents after the stall.
  assign redirect = ~hz & (bus.branchTaken | bus.jump);
  // An end marker on the wrong path (flushed) or held by a stall is not taken.
  assign enter_drain = bus.endProgram & ~hz & ~redirect;

  always_comb begin
    bus.pcSelect   = 1'b0;
    bus.stall      = 1'b0;
    bus.ifIdFlush  = 1'b0;
    bus.idExBubble = 1'b0;
    bus.halted     = 1'b0;
    if (reset) begin
      bus.pcSelect   = 1'b1;
      bus.ifIdFlush  = 1'b1;
      bus.idExBubble = 1'b1;
    end else begin
      unique case (state_q)
        START: bus.pcSelect = 1'b1;
        RUN: begin
          bus.stall      = hz;
          bus.idExBubble = hz;
          bus.ifIdFlush  = redirect;
        end
        DRAIN: begin
          bus.stall     = 1'b1;
          bus.ifIdFlush = 1'b1;
        end
        HALT: begin
          bus.halted     = 1'b1;
          bus.stall      = 1'b1;
          bus.ifIdFlush  = 1'b1;
          bus.idExBubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.stallCount = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START;
      drain_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        START: state_q <= RUN;
        RUN: begin
          if (hz && (cnt_q != {STALL_CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
          if (enter_drain) begin
            state_q <= DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_q == 4'd0) state_q <= HALT;
          else                 drain_q <= drain_q - 4'd1;
        end
        HALT: state_q <= HALT;
        default: state_q <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;
  localparam int DRAIN = 4;
  localparam int W     = 16;
  localparam int CMAX  = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_control_if #(.STALL_CNT_W(W)) bus ();

  pipeline_control #(.DRAIN_CYCLES(DRAIN), .STALL_CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          known;
    logic [1:0]  st;
    logic        pc, stl, fl, bb, h;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0..3 = start/run/drain/halt, -1 = unknown before
  // the first reset edge; drain tracked as cycles remaining.
  int m_mode = -1;
  int m_left = 0;
  int m_cnt  = 0;

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pcSelect",   bus.pcSelect,   e.pc);
      chk("stall",      bus.stall,      e.stl);
      chk("ifIdFlush",  bus.ifIdFlush,  e.fl);
      chk("idExBubble", bus.idExBubble, e.bb);
      chk("halted",     bus.halted,     e.h);
      if (e.known) begin
        chk("state",      bus.state,      e.st);
        chk("stallCount", bus.stallCount, e.cnt);
      end
    end
  end

  // Applies one cycle of inputs, queues the expected outputs for that cycle,
  // then advances the model across the coming edge.
  task automatic drive(input bit r, input bit ep, input bit br, input bit j,
                       input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u2);
    exp_t e;
    bit hz, rdr;
    @(posedge clk); #1;
    reset = r;
    bus.endProgram = ep; bus.branchTaken = br; bus.jump = j;
    bus.idExMemRead = mr; bus.idExRd = rd; bus.ifIdRs1 = rs1;
    bus.ifIdRs2 = rs2; bus.ifIdUsesRs2 = u2;
    hz  = mr && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
    rdr = !hz && (br || j);
    e.known = (m_mode >= 0);
    e.st  = 2'(m_mode < 0 ? 0 : m_mode);
    e.cnt = W'(m_cnt);
    e.pc = 0; e.stl = 0; e.fl = 0; e.bb = 0; e.h = 0;
    if (r) begin
      e.pc = 1; e.fl = 1; e.bb = 1;
    end else if (m_mode == 0) begin
      e.pc = 1;
    end else if (m_mode == 1) begin
      e.stl = hz; e.bb = hz; e.fl = rdr;
    end else if (m_mode == 2) begin
      e.stl = 1; e.fl = 1;
    end else if (m_mode == 3) begin
      e.h = 1; e.stl = 1; e.fl = 1; e.bb = 1;
    end
    q.push_back(e);
    if (r) begin
      m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (hz && m_cnt < CMAX) m_cnt++;
      if (ep && !hz && !rdr) begin
        m_mode = 2; m_left = DRAIN;
      end
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) m_mode = 3;
    end
  endtask

  task automatic idle(input bit r);
    drive(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rnd(input int ep_pct, input int rst_pct);
    drive($urandom_range(0, 99) < rst_pct,
          $urandom_range(0, 99) < ep_pct,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1, pick_reg(), pick_reg(), pick_reg(),
          $urandom_range(0, 1) == 1);
  endtask

  initial begin
    bus.endProgram = 0; bus.branchTaken = 0; bus.jump = 0;
    bus.idExMemRead = 0; bus.idExRd = 0; bus.ifIdRs1 = 0;
    bus.ifIdRs2 = 0; bus.ifIdUsesRs2 = 0;

    // reset, start cycle, run
    idle(1); idle(1);
    idle(0);
    idle(0);
    // load-use hazard cases
    drive(0, 0, 0, 0, 1, 5, 5, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 1, 5, 0);
    drive(0, 0, 0, 0, 1, 5, 1, 5, 1);
    // flush and stall priority
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 5, 5, 0, 0);
    // random run traffic without end marker
    repeat (300) rnd(0, 0);
    // end with a jump is ignored; end under hazard waits a cycle
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 7, 7, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // drain then halt, random inputs ignored
    repeat (25) rnd(50, 0);
    // reset in the middle of drain
    idle(1); idle(0); idle(0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    idle(1); idle(0); idle(0);
    // stall counter saturation
    repeat (CMAX + 5) drive(0, 0, 0, 0, 1, 9, 9, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) rnd(0, 0);
    // random traffic with end markers and occasional resets
    idle(1);
    repeat (3000) rnd(3, 1);

    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Sequencing and hazard controller for the pipelined fetch unit and IF/ID/ID-EX pipeline registers.
- Asserts the start-address select for the first fetch after reset.
- Detects load-use hazards and drives stall and bubble signals.
- Flushes IF/ID on taken branches and jumps.
- On a program-end fetch, drains the pipeline for a fixed number of cycles, then halts.
- Sits beside the fetch unit at the top level of the CPU.

Parameters:
- DRAIN_CYCLES, 4, cycles of bubble injection after the end instruction is accepted, before halted asserts (1..15).
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- endProgram  input  1  fetch unit's end-of-program detect on the current fetched instruction.
- branchTaken  input  1  fetch unit's branchOut (already gated by ~stall).
- jump  input  1  jump or jump-register decoded in ID.
- idExMemRead  input  1  instruction in EX is a load.
- idExRd  input  5  destination register of the instruction in EX.
- ifIdRs1  input  5  source register 1 of the instruction in ID.
- ifIdRs2  input  5  source register 2 of the instruction in ID.
- ifIdUsesRs2  input  1  instruction in ID reads rs2.
- pcSelect  output  1  1 = fetch from startAddress.
- stall  output  1  hold PC and IF/ID.
- ifIdFlush  output  1  clear IF/ID to NOP at next edge.
- idExBubble  output  1  insert NOP into ID/EX at next edge.
- halted  output  1  program complete.
- state  output  2  current FSM state (debug).
- stallCount  output  STALL_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- FSM encoding: START=0, RUN=1, DRAIN=2, HALT=3. All transitions occur on the rising edge of clk.
- While reset=1, at each edge:
  - state<=START, drain counter<=0, stallCount<=0.
  - Outputs during reset: pcSelect=1, stall=0, ifIdFlush=1, idExBubble=1, halted=0.
  - Reset mid-DRAIN or mid-HALT behaves identically.
- START:
  - pcSelect=1, stall=0, ifIdFlush=0, idExBubble=0.
  - Lasts exactly one cycle, then goes to RUN unconditionally.
  - endProgram is ignored in START.
- RUN: pcSelect=0. All outputs are combinational from the current inputs.
  - Define hz = idExMemRead & (idExRd!=0) & ((idExRd==ifIdRs1) | (ifIdUsesRs2 & idExRd==ifIdRs2)).
  - stall=hz and idExBubble=hz.
  - ifIdFlush = ~hz & (branchTaken | jump). Stall has priority: a jump that coincides with a hazard is not flushed that cycle; it re-presents after the stall.
  - Enter DRAIN when endProgram & ~hz & ~ifIdFlush. A wrong-path end instruction (same cycle as a flush) is ignored. One stalled by a hazard is re-evaluated next cycle.
  - On the DRAIN transition, load the drain counter with DRAIN_CYCLES-1.
- DRAIN:
  - stall=1, ifIdFlush=1, idExBubble=0. Older instructions complete; no new fetches enter.
  - Counter decrements each cycle. At counter==0, go to HALT.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
  - branchTaken, jump and the hazard inputs are ignored.
- HALT:
  - halted=1, stall=1, ifIdFlush=1, idExBubble=1.
  - Stays in HALT until reset.
- stallCount:
  - Increments by 1 on each edge where state==RUN and hz=1.
  - Saturates at all-ones with no wrap.
  - Holds its value in DRAIN and HALT.

Test Plan:
- Reset for 2 cycles, then release -> pcSelect=1 for exactly 1 cycle with state=0, then state=1, pcSelect=0, stall=0, halted=0.
- RUN with idExMemRead=1, idExRd=5, ifIdRs1=5 -> stall=idExBubble=1, ifIdFlush=0, stallCount 0->1. Same with idExRd=0 -> no stall. With ifIdRs2=5, ifIdUsesRs2=0 -> no stall.
- branchTaken=1 with no hazard -> ifIdFlush=1 for that cycle. jump=1 together with a hazard -> ifIdFlush=0, stall=1.
- endProgram=1 in RUN with no hazard or flush (DRAIN_CYCLES=4) -> state=2 for exactly 4 cycles with stall=ifIdFlush=1, then state=3, halted=1, held for 20 cycles.
- endProgram=1 together with jump=1 -> state stays RUN. endProgram together with a hazard -> RUN that cycle; DRAIN the next cycle once the hazard clears.
- Force 65540 consecutive hazard cycles -> stallCount=16'hFFFF with no wrap. Assert reset during DRAIN -> state=0, stallCount=0, pcSelect=1 on the next cycle.
